// File: rtl/adc_gain_offset_sched.sv
// Round-robin scheduler sharing one gain/offset multiply-add pipeline across N_CH ADC channels.
// Latency grant->o_valid 3 cycles, 1 result/cycle; i_enable=0 stops new grants while in-flight ops drain.
// Macro GAIN_OFFSET_SAT_EN: when defined, results clamp to signed 32-bit; otherwise they wrap.
module adc_gain_offset_sched #(
    parameter int N_CH = 7,
    parameter int DW   = 16,
    parameter int FRAC = 16,
    parameter int CHW  = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    input  logic [N_CH*DW-1:0]   i_adc_data,
    input  logic [N_CH-1:0]      i_adc_valid,
    input  logic [N_CH*32-1:0]   i_gain,
    input  logic [N_CH*32-1:0]   i_offset,
    input  logic [N_CH-1:0]      i_overrun_clr,
    output logic [31:0]          o_data,
    output logic [CHW-1:0]       o_ch,
    output logic                 o_valid,
    output logic [N_CH*32-1:0]   o_result,
    output logic [N_CH-1:0]      o_overrun,
    output logic                 o_busy
);

    logic [N_CH-1:0]           pend_q, pend_d;
    logic [N_CH-1:0][DW-1:0]   samp_q, samp_d;
    logic [CHW-1:0]            ptr_q, ptr_d;
    logic [N_CH-1:0]           ovr_q, ovr_d;

    logic                      s1_vld_q, s1_vld_d;
    logic signed [DW-1:0]      s1_x_q, s1_x_d;
    logic signed [31:0]        s1_gain_q, s1_gain_d;
    logic signed [31:0]        s1_off_q, s1_off_d;
    logic [CHW-1:0]            s1_ch_q, s1_ch_d;

    logic                      s2_vld_q, s2_vld_d;
    logic signed [47:0]        s2_p_q, s2_p_d;
    logic signed [31:0]        s2_off_q, s2_off_d;
    logic [CHW-1:0]            s2_ch_q, s2_ch_d;

    logic                      o_valid_q, o_valid_d;
    logic [31:0]               o_data_q, o_data_d;
    logic [CHW-1:0]            o_ch_q, o_ch_d;
    logic [N_CH-1:0][31:0]     o_result_q, o_result_d;

    logic                      gnt_vld;
    logic [CHW-1:0]            gnt_idx;
    logic [N_CH-1:0]           gnt_oh;
    logic signed [47:0]        x_ext, g_ext;
    logic signed [33:0]        s3_sh, s3_sum;
    logic [31:0]               res;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        // First pass finds the lowest pending channel (wrap candidate); second pass
        // overrides it with the lowest pending channel at or above the pointer.
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (pend_q[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = CHW'(k);
            end
        end
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (pend_q[k] && k >= int'(ptr_q)) begin
                gnt_idx = CHW'(k);
            end
        end
        gnt_vld = gnt_vld & i_enable;
        gnt_oh  = gnt_vld ? (N_CH'(1) << gnt_idx) : '0;

        ptr_d = ptr_q;
        if (gnt_vld) begin
            ptr_d = (gnt_idx == CHW'(N_CH - 1)) ? '0 : gnt_idx + CHW'(1);
        end

        pend_d = (pend_q & ~gnt_oh) | i_adc_valid;
        ovr_d  = (ovr_q & ~i_overrun_clr) | (i_adc_valid & pend_q & ~gnt_oh);
        samp_d = samp_q;
        for (int k = 0; k < N_CH; k++) begin
            if (i_adc_valid[k]) begin
                samp_d[k] = i_adc_data[k*DW +: DW];
            end
        end

        // Factors are captured only at issue so register writes cannot tear an op.
        s1_vld_d  = gnt_vld;
        s1_x_d    = s1_x_q;
        s1_gain_d = s1_gain_q;
        s1_off_d  = s1_off_q;
        s1_ch_d   = s1_ch_q;
        if (gnt_vld) begin
            s1_x_d    = samp_q[gnt_idx];
            s1_gain_d = i_gain[int'(gnt_idx)*32 +: 32];
            s1_off_d  = i_offset[int'(gnt_idx)*32 +: 32];
            s1_ch_d   = gnt_idx;
        end

        x_ext    = 48'(s1_x_q);
        g_ext    = 48'(s1_gain_q);
        s2_vld_d = s1_vld_q;
        s2_p_d   = s2_p_q;
        s2_off_d = s2_off_q;
        s2_ch_d  = s2_ch_q;
        if (s1_vld_q) begin
            s2_p_d   = x_ext * g_ext;
            s2_off_d = s1_off_q;
            s2_ch_d  = s1_ch_q;
        end

        s3_sh  = 34'(s2_p_q >>> FRAC);
        s3_sum = s3_sh + 34'(s2_off_q);
`ifdef GAIN_OFFSET_SAT_EN
        if (s3_sum > 34'sh0_7FFF_FFFF) begin
            res = 32'h7FFF_FFFF;
        end else if (s3_sum < 34'sh3_8000_0000) begin
            res = 32'h8000_0000;
        end else begin
            res = 32'(s3_sum);
        end
`else
        res = 32'(s3_sum);
`endif

        o_valid_d  = s2_vld_q;
        o_data_d   = o_data_q;
        o_ch_d     = o_ch_q;
        o_result_d = o_result_q;
        if (s2_vld_q) begin
            o_data_d            = res;
            o_ch_d              = s2_ch_q;
            o_result_d[s2_ch_q] = res;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_q     <= '0;
            samp_q     <= '0;
            ptr_q      <= '0;
            ovr_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_x_q     <= '0;
            s1_gain_q  <= '0;
            s1_off_q   <= '0;
            s1_ch_q    <= '0;
            s2_vld_q   <= 1'b0;
            s2_p_q     <= '0;
            s2_off_q   <= '0;
            s2_ch_q    <= '0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_ch_q     <= '0;
            o_result_q <= '0;
        end else begin
            pend_q     <= pend_d;
            samp_q     <= samp_d;
            ptr_q      <= ptr_d;
            ovr_q      <= ovr_d;
            s1_vld_q   <= s1_vld_d;
            s1_x_q     <= s1_x_d;
            s1_gain_q  <= s1_gain_d;
            s1_off_q   <= s1_off_d;
            s1_ch_q    <= s1_ch_d;
            s2_vld_q   <= s2_vld_d;
            s2_p_q     <= s2_p_d;
            s2_off_q   <= s2_off_d;
            s2_ch_q    <= s2_ch_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            o_ch_q     <= o_ch_d;
            o_result_q <= o_result_d;
        end
    end

    assign o_data    = o_data_q;
    assign o_ch      = o_ch_q;
    assign o_valid   = o_valid_q;
    assign o_result  = o_result_q;
    assign o_overrun = ovr_q;
    assign o_busy    = (|pend_q) | s1_vld_q | s2_vld_q | o_valid_q;

endmodule

// File: tb/tb_adc_gain_offset_sched.sv
// Bench for adc_gain_offset_sched: directed scenarios plus randomized traffic against a
// queue-based reference model that tracks pending samples and results due per cycle.
module tb_adc_gain_offset_sched;
    localparam int N_CH = 7;
    localparam int DW   = 16;
    localparam int FRAC = 16;
    localparam int CHW  = 3;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n = 1'b1;
    logic                 i_enable = 1'b0;
    logic [N_CH*DW-1:0]   i_adc_data = '0;
    logic [N_CH-1:0]      i_adc_valid = '0;
    logic [N_CH*32-1:0]   i_gain = '0;
    logic [N_CH*32-1:0]   i_offset = '0;
    logic [N_CH-1:0]      i_overrun_clr = '0;
    logic [31:0]          o_data;
    logic [CHW-1:0]       o_ch;
    logic                 o_valid;
    logic [N_CH*32-1:0]   o_result;
    logic [N_CH-1:0]      o_overrun;
    logic                 o_busy;

    adc_gain_offset_sched #(.N_CH(N_CH), .DW(DW), .FRAC(FRAC), .CHW(CHW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
        .i_adc_data(i_adc_data), .i_adc_valid(i_adc_valid),
        .i_gain(i_gain), .i_offset(i_offset), .i_overrun_clr(i_overrun_clr),
        .o_data(o_data), .o_ch(o_ch), .o_valid(o_valid), .o_result(o_result),
        .o_overrun(o_overrun), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [DW-1:0]   adc_x  [N_CH];
    logic [31:0]     gain_r [N_CH];
    logic [31:0]     off_r  [N_CH];
    logic [N_CH-1:0] vld_r = '0;
    logic [N_CH-1:0] clr_r = '0;

    typedef struct { int due; int ch; logic [31:0] res; } exp_t;
    exp_t              q[$];
    bit                m_pend [N_CH];
    logic [DW-1:0]     m_samp [N_CH];
    int                m_ptr;
    logic [N_CH-1:0]   m_ovr;
    logic              exp_valid, exp_busy;
    logic [31:0]       exp_data;
    int                exp_ch;
    logic [N_CH*32-1:0] exp_result;

    int          got_ch[$];
    logic [31:0] got_dat[$];
    int          got_cyc[$];

    function automatic logic [31:0] calc(logic [DW-1:0] x, logic [31:0] g, logic [31:0] o);
        longint p, s;
        p = longint'($signed(x)) * longint'($signed(g));
        s = (p >>> FRAC) + longint'($signed(o));
`ifdef GAIN_OFFSET_SAT_EN
        if (s > 2147483647) return 32'h7FFF_FFFF;
        if (s < -longint'(2147483647) - 1) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    task automatic drive();
        for (int k = 0; k < N_CH; k++) begin
            i_adc_data[k*DW +: DW] = adc_x[k];
            i_gain[k*32 +: 32]     = gain_r[k];
            i_offset[k*32 +: 32]   = off_r[k];
        end
        i_adc_valid   = vld_r;
        i_overrun_clr = clr_r;
    endtask

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < N_CH; k++) begin
            m_pend[k] = 1'b0;
            m_samp[k] = '0;
        end
        m_ptr = 0; m_ovr = '0;
        exp_valid = 1'b0; exp_busy = 1'b0; exp_data = '0; exp_ch = 0; exp_result = '0;
    endtask

    // One clock: model the grant decision with the inputs as driven, advance, sample at +1.
    task automatic tick();
        int g;
        bit any;
        drive();
        g = -1;
        if (i_enable) begin
            for (int j = 0; j < N_CH; j++) begin
                int k;
                k = (m_ptr + j) % N_CH;
                if (g < 0 && m_pend[k]) g = k;
            end
        end
        if (g >= 0) begin
            q.push_back('{cyc + 3, g, calc(m_samp[g], gain_r[g], off_r[g])});
            m_pend[g] = 1'b0;
            m_ptr = (g == N_CH - 1) ? 0 : g + 1;
        end
        m_ovr = m_ovr & ~clr_r;
        for (int k = 0; k < N_CH; k++) begin
            if (vld_r[k]) begin
                if (m_pend[k]) m_ovr[k] = 1'b1;
                m_pend[k] = 1'b1;
                m_samp[k] = adc_x[k];
            end
        end
        @(posedge i_clk);
        #1;
        cyc++;
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        exp_valid = (q.size() > 0 && q[0].due == cyc);
        if (exp_valid) begin
            exp_data = q[0].res;
            exp_ch   = q[0].ch;
            exp_result[q[0].ch*32 +: 32] = q[0].res;
        end
        any = 1'b0;
        for (int k = 0; k < N_CH; k++) any |= m_pend[k];
        exp_busy = any || (q.size() > 0);
        if (o_valid) begin
            got_ch.push_back(int'(o_ch));
            got_dat.push_back(o_data);
            got_cyc.push_back(cyc);
        end
        vld_r = '0;
        clr_r = '0;
        drive();
    endtask

    task automatic clear_got();
        got_ch.delete(); got_dat.delete(); got_cyc.delete();
    endtask

    task automatic test_reset();
        model_reset();
        #2 i_rst_n = 1'b0;
        #1;
        n_chk++;
        if (o_valid !== 1'b0 || o_data !== 32'h0 || o_ch !== '0 || o_result !== '0 ||
            o_overrun !== '0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b data=%h ch=%0d ovr=%b busy=%b, required all 0",
                     o_valid, o_data, o_ch, o_overrun, o_busy);
        end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        i_enable = 1'b1;
    endtask

    task automatic test_unity_gain();
        int vcyc;
        clear_got();
        gain_r[0] = 32'h0001_0000; off_r[0] = 32'h0; adc_x[0] = 16'd1000; vld_r[0] = 1'b1;
        vcyc = cyc;
        tick();
        for (int i = 0; i < 8; i++) tick();
        n_chk++;
        if (got_ch.size() != 1) begin
            n_fail++;
            $display("FAIL t1_count: results=%0d, required 1", got_ch.size());
        end else begin
            n_chk += 2;
            if (got_cyc[0] - vcyc != 4) begin
                n_fail++;
                $display("FAIL t1_latency: valid->o_valid %0d cycles, required 4", got_cyc[0] - vcyc);
            end
            if (got_dat[0] !== 32'd1000 || got_ch[0] != 0) begin
                n_fail++;
                $display("FAIL t1_data: data=%h ch=%0d, required 000003e8 ch 0", got_dat[0], got_ch[0]);
            end
        end
    endtask

    task automatic test_neg_offset();
        clear_got();
        gain_r[4] = 32'h0002_0000; off_r[4] = 32'hFFFF_FFFB; adc_x[4] = -16'sd100; vld_r[4] = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        n_chk += 2;
        if (got_dat.size() != 1 || got_dat[0] !== 32'hFFFF_FF33 || got_ch[0] != 4) begin
            n_fail++;
            $display("FAIL t2_data: n=%0d data=%h, required one result ffffff33 on ch 4",
                     got_dat.size(), (got_dat.size() > 0) ? got_dat[0] : 32'h0);
        end
        if (o_result[4*32 +: 32] !== 32'hFFFF_FF33) begin
            n_fail++;
            $display("FAIL t2_result_reg: o_result[4]=%h, required ffffff33", o_result[4*32 +: 32]);
        end
    endtask

    task automatic test_round_robin();
        vld_r[6] = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        clear_got();
        vld_r = 7'b100_1001;
        for (int i = 0; i < 8; i++) tick();
        n_chk++;
        if (got_ch.size() != 3 || got_ch[0] != 0 || got_ch[1] != 3 || got_ch[2] != 6 ||
            got_cyc[1] != got_cyc[0] + 1 || got_cyc[2] != got_cyc[1] + 1) begin
            n_fail++;
            $display("FAIL t3_order: n=%0d chs=%p cycles=%p, required 0,3,6 consecutive",
                     got_ch.size(), got_ch, got_cyc);
        end
        clear_got();
        vld_r = 7'b010_0001;
        for (int i = 0; i < 8; i++) tick();
        n_chk++;
        if (got_ch.size() != 2 || got_ch[0] != 0 || got_ch[1] != 5) begin
            n_fail++;
            $display("FAIL t3_ptr_wrap: chs=%p, required 0 then 5", got_ch);
        end
    endtask

    task automatic test_overrun();
        clear_got();
        gain_r[2] = 32'h0001_0000; off_r[2] = 32'h0;
        i_enable = 1'b0;
        adc_x[2] = 16'd5; vld_r[2] = 1'b1; tick();
        adc_x[2] = 16'd9; vld_r[2] = 1'b1; tick();
        tick();
        n_chk += 2;
        if (o_overrun[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_overrun_set: o_overrun=%b, required bit 2 set", o_overrun);
        end
        if (o_busy !== 1'b1 || got_ch.size() != 0) begin
            n_fail++;
            $display("FAIL t4_hold: busy=%b results=%0d, required busy 1 with no results", o_busy, got_ch.size());
        end
        i_enable = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        n_chk++;
        if (got_dat.size() != 1 || got_dat[0] !== 32'd9 || got_ch[0] != 2) begin
            n_fail++;
            $display("FAIL t4_single_result: n=%0d data=%h, required one result 9 on ch 2",
                     got_dat.size(), (got_dat.size() > 0) ? got_dat[0] : 32'h0);
        end
        clr_r[2] = 1'b1; tick();
        n_chk++;
        if (o_overrun[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_overrun_clr: o_overrun=%b, required bit 2 clear", o_overrun);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] want;
`ifdef GAIN_OFFSET_SAT_EN
        want = 32'h7FFF_FFFF;
`else
        want = 32'hBFFF_7FFE;
`endif
        clear_got();
        gain_r[1] = 32'h7FFF_FFFF; off_r[1] = 32'h7FFF_FFFF; adc_x[1] = 16'h7FFF; vld_r[1] = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        n_chk++;
        if (got_dat.size() != 1 || got_dat[0] !== want) begin
            n_fail++;
            $display("FAIL t5_extreme: n=%0d data=%h, required %h", got_dat.size(),
                     (got_dat.size() > 0) ? got_dat[0] : 32'h0, want);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            int k;
            for (int c = 0; c < N_CH; c++) adc_x[c] = DW'($urandom);
            k = $urandom_range(0, N_CH - 1);
            gain_r[k] = $urandom;
            if ($urandom_range(0, 1) == 1) gain_r[k] = {{14{gain_r[k][17]}}, gain_r[k][17:0]};
            off_r[k]  = $urandom;
            vld_r = (i % 100 < 10) ? '1 : N_CH'($urandom & $urandom);
            clr_r = ($urandom_range(0, 7) == 0) ? N_CH'($urandom) : '0;
            i_enable = ($urandom_range(0, 9) != 0);
            tick();
            n_chk += 3;
            if (o_valid !== exp_valid ||
                (exp_valid && (o_data !== exp_data || int'(o_ch) != exp_ch))) begin
                n_fail++;
                $display("FAIL rnd_output cyc %0d: valid=%b data=%h ch=%0d, required valid=%b data=%h ch=%0d",
                         cyc, o_valid, o_data, o_ch, exp_valid, exp_data, exp_ch);
            end
            if (o_overrun !== m_ovr) begin
                n_fail++;
                $display("FAIL rnd_overrun cyc %0d: %b, required %b", cyc, o_overrun, m_ovr);
            end
            if (o_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL rnd_busy cyc %0d: %b, required %b", cyc, o_busy, exp_busy);
            end
        end
        i_enable = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        n_chk += 2;
        if (o_result !== exp_result) begin
            n_fail++;
            $display("FAIL rnd_result_regs: %h, required %h", o_result, exp_result);
        end
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_drained: busy=%b, required 0", o_busy);
        end
    endtask

    task automatic test_reset_inflight();
        int seen;
        for (int c = 0; c < N_CH; c++) begin
            gain_r[c] = 32'h0001_0000; off_r[c] = 32'h10; adc_x[c] = DW'(c + 1);
        end
        vld_r = '1;
        for (int i = 0; i < 4; i++) tick();
        n_chk++;
        if (o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL t6_prefill: o_valid=%b, required 1 before reset", o_valid);
        end
        #3 i_rst_n = 1'b0;
        #1;
        model_reset();
        n_chk++;
        if (o_valid !== 1'b0 || o_data !== 32'h0 || o_ch !== '0 || o_result !== '0 ||
            o_overrun !== '0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_async_clear: valid=%b data=%h busy=%b, required all 0",
                     o_valid, o_data, o_busy);
        end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_valid) seen++;
        end
        n_chk++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL t6_no_valid_after: %0d strobes, required 0", seen);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < N_CH; k++) begin
            adc_x[k] = '0; gain_r[k] = '0; off_r[k] = '0;
        end
        drive();
        test_reset();
        test_unity_gain();
        test_neg_offset();
        test_round_robin();
        test_overrun();
        test_saturation();
        test_random();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
